// File: rtl/par_to_serial_gen.sv
// par_to_serial_gen
//   Serialises WIDTH-bit parallel words onto a single bit stream (IDL),
//   one bit per clk_32f cycle with no gaps between words. When no word is
//   offered at a word boundary, IDLE_PATTERN is sent instead.
//
// Parameters
//   WIDTH        word width in bits (2..32)
//   IDLE_PATTERN word sent when no data is available
//   LSB_FIRST    0: MSB first, 1: LSB first
//
// Ports
//   clk_32f      in   serial bit clock (rising edge)
//   reset        in   synchronous, active-high
//   active       in   link enable; low forces IDLE_PATTERN
//   data_in      in   parallel word to serialise
//   valid_in     in   data_in holds a word to send
//   ready_out    out  combinational: word accepted on this cycle
//   IDL          out  serial bit stream (registered)
//   idle_out     out  word currently on IDL is IDLE_PATTERN
//   word_done    out  pulse on the last bit of each word
//   underrun_cnt out  idle words inserted while active, saturating at 255
module par_to_serial_gen #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] IDLE_PATTERN = 8'hBC,
  parameter logic             LSB_FIRST    = 1'b0
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             active,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             IDL,
  output logic             idle_out,
  output logic             word_done,
  output logic [7:0]       underrun_cnt
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_RST     = 2'd0;
  localparam logic [1:0] ST_IDLE_TX = 2'd1;
  localparam logic [1:0] ST_DATA_TX = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             idl_q, idl_d;
  logic             idle_out_q, idle_out_d;
  logic             word_done_q, word_done_d;
  logic [7:0]       underrun_q, underrun_d;
  logic             boundary;

  always_comb begin
    boundary  = (state_q == ST_RST) || (bit_cnt_q == LAST);
    ready_out = boundary && active && !reset;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + CW'(1);
    shift_d    = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
    underrun_d = underrun_q;

    if (boundary) begin
      bit_cnt_d = '0;
      if (valid_in && ready_out) begin
        shift_d = data_in;
        state_d = ST_DATA_TX;
      end else begin
        shift_d = IDLE_PATTERN;
        state_d = ST_IDLE_TX;
      end
      if (active && !valid_in && (underrun_q != 8'hFF)) begin
        underrun_d = underrun_q + 8'd1;
      end
    end

    // The serial output is registered, so it is taken from the next shift
    // value: the first bit of a word appears the cycle after its load edge.
    idl_d       = LSB_FIRST ? shift_d[0] : shift_d[WIDTH-1];
    idle_out_d  = (state_d != ST_DATA_TX);
    word_done_d = (bit_cnt_d == LAST);
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= ST_RST;
      bit_cnt_q   <= '0;
      shift_q     <= IDLE_PATTERN;
      idl_q       <= 1'b0;
      idle_out_q  <= 1'b1;
      word_done_q <= 1'b0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idl_q       <= idl_d;
      idle_out_q  <= idle_out_d;
      word_done_q <= word_done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign IDL          = idl_q;
  assign idle_out     = idle_out_q;
  assign word_done    = word_done_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_par_to_serial_gen.sv
module tb_par_to_serial_gen;

  localparam int W = 8;
  localparam logic [W-1:0] IDLE = 8'hBC;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         active = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] data_in = '0;

  logic       ready_m, idl_m, idle_m, done_m;
  logic [7:0] uc_m;
  logic       ready_l, idl_l, idle_l, done_l;
  logic [7:0] uc_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  par_to_serial_gen #(.WIDTH(W), .IDLE_PATTERN(IDLE), .LSB_FIRST(1'b0)) dut_msb (
    .clk_32f(clk), .reset(reset), .active(active), .data_in(data_in),
    .valid_in(valid_in), .ready_out(ready_m), .IDL(idl_m), .idle_out(idle_m),
    .word_done(done_m), .underrun_cnt(uc_m)
  );

  par_to_serial_gen #(.WIDTH(W), .IDLE_PATTERN(IDLE), .LSB_FIRST(1'b1)) dut_lsb (
    .clk_32f(clk), .reset(reset), .active(active), .data_in(data_in),
    .valid_in(valid_in), .ready_out(ready_l), .IDL(idl_l), .idle_out(idle_l),
    .word_done(done_l), .underrun_cnt(uc_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted or idle word is expanded into a queue of
  // expected output bits; the stream simply drains one entry per cycle and a
  // new word is fetched whenever nothing is pending.
  typedef struct packed {
    logic idl;
    logic idle;
    logic done;
  } obit_t;

  obit_t        qm[$];
  obit_t        ql[$];
  obit_t        cm, cl, e;
  logic         m_on = 1'b0;
  int           m_uc = 0;
  logic [W-1:0] m_word;
  logic         m_is_idle;

  always @(posedge clk) begin
    if (reset) begin
      qm.delete();
      ql.delete();
      m_uc = 0;
      cm.idl = 1'b0; cm.idle = 1'b1; cm.done = 1'b0;
      cl = cm;
      m_on = 1'b1;
    end else if (m_on) begin
      if (qm.size() == 0) begin
        if (active && valid_in) begin
          m_word = data_in;
          m_is_idle = 1'b0;
        end else begin
          m_word = IDLE;
          m_is_idle = 1'b1;
          if (active && m_uc < 255) m_uc++;
        end
        for (int i = 0; i < W; i++) begin
          e.idle = m_is_idle;
          e.done = (i == W - 1);
          e.idl  = m_word[W-1-i];
          qm.push_back(e);
          e.idl  = m_word[i];
          ql.push_back(e);
        end
      end
      cm = qm.pop_front();
      cl = ql.pop_front();
    end
  end

  logic exp_ready;
  always @(negedge clk) begin
    if (m_on) begin
      exp_ready = (qm.size() == 0) && active && !reset;
      check("ready_msb", {31'd0, ready_m}, {31'd0, exp_ready});
      check("ready_lsb", {31'd0, ready_l}, {31'd0, exp_ready});
      check("idl_msb",   {31'd0, idl_m},   {31'd0, cm.idl});
      check("idl_lsb",   {31'd0, idl_l},   {31'd0, cl.idl});
      check("idle_msb",  {31'd0, idle_m},  {31'd0, cm.idle});
      check("idle_lsb",  {31'd0, idle_l},  {31'd0, cl.idle});
      check("done_msb",  {31'd0, done_m},  {31'd0, cm.done});
      check("done_lsb",  {31'd0, done_l},  {31'd0, cl.done});
      check("uc_msb",    {24'd0, uc_m},    m_uc);
      check("uc_lsb",    {24'd0, uc_l},    m_uc);
    end
  end

  task automatic cyc(input logic r, input logic a, input logic v, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    reset = r; active = a; valid_in = v; data_in = d;
  endtask

  typedef struct {
    logic         r, a, v;
    logic [W-1:0] d;
    logic         chk;
    logic         ready, idl, idle, done;
    logic [7:0]   uc;
  } vec_t;

  vec_t tab[12];
  logic [23:0] seq24;
  logic [15:0] seq16;
  logic        idle_all, ready_any;

  initial begin
    //              r     a     v     d       chk   rdy   idl   idle  done  uc
    tab[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tab[2]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    tab[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tab[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tab[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tab[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tab[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tab[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tab[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tab[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    tab[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};

    // A5 MSB-first after reset, followed by an underrun idle word
    for (int i = 0; i < 12; i++) begin
      cyc(tab[i].r, tab[i].a, tab[i].v, tab[i].d);
      @(negedge clk);
      check("tab_ready", {31'd0, ready_m}, {31'd0, tab[i].ready});
      if (tab[i].chk) begin
        check("tab_idl",  {31'd0, idl_m},  {31'd0, tab[i].idl});
        check("tab_idle", {31'd0, idle_m}, {31'd0, tab[i].idle});
        check("tab_done", {31'd0, done_m}, {31'd0, tab[i].done});
        check("tab_uc",   {24'd0, uc_m},   {24'd0, tab[i].uc});
      end
    end

    // Link inactive: pure idle pattern, no underruns counted
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    idle_all = 1'b1;
    seq24 = '0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h55);
      @(negedge clk);
      if (i >= 1) begin
        seq24 = {seq24[22:0], idl_m};
        idle_all = idle_all & idle_m;
      end
    end
    check("inactive_stream", {8'd0, seq24}, 32'h00BCBCBC);
    check("inactive_idle",   {31'd0, idle_all}, 32'd1);
    check("inactive_uc",     {24'd0, uc_m}, 32'd0);

    // Underrun saturation over 300 idle words
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 300 * W; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("underrun_sat", {24'd0, uc_m}, 32'd255);

    // LSB-first 01 then 80 back to back
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 8'h01);
    seq16 = '0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, (i < 8), 8'h80);
      @(negedge clk);
      seq16 = {seq16[14:0], idl_l};
    end
    check("lsb_b2b", {16'd0, seq16}, 32'h00008001);

    // Active drops at bit 3 of an FF word
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 8'hFF);
    seq16 = '0;
    ready_any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 3) cyc(1'b0, 1'b1, 1'b0, '0);
      else       cyc(1'b0, 1'b0, 1'b1, 8'h00);
      @(negedge clk);
      seq16 = {seq16[14:0], idl_m};
      if (i >= 3) ready_any = ready_any | ready_m;
    end
    check("active_drop_stream", {16'd0, seq16}, 32'h0000FFBC);
    check("active_drop_ready",  {31'd0, ready_any}, 32'd0);

    // Reset in the middle of a data word
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 8'hC3);
    @(negedge clk);
    check("midreset_idl",   {31'd0, idl_m},   32'd0);
    check("midreset_idle",  {31'd0, idle_m},  32'd1);
    check("midreset_ready", {31'd0, ready_m}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("midreset_reload_idl",  {31'd0, idl_m},  32'd1);
    check("midreset_reload_idle", {31'd0, idle_m}, 32'd0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0),
          $urandom_range(1), W'($urandom));
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/par_to_serial_gen.md
PAR_TO_SERIAL_GEN -- requirements
Module: par_to_serial_gen

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, giving the word width in bits; the legal range SHALL be 2..32.
REQ-002 The block SHALL expose parameter IDLE_PATTERN, default 8'hBC, which is the WIDTH-bit word sent when no data is available.
REQ-003 The block SHALL expose parameter LSB_FIRST, default 0, where 0 selects MSB-first and 1 selects LSB-first serialisation.
REQ-004 The block SHALL have port clk_32f  input  1  serial bit clock; it is the only clock, and all logic SHALL use its rising edge.
REQ-005 The block SHALL have port reset  input  1  reset that is synchronous and active-high.
REQ-006 The block SHALL have port active  input  1  link enable; when low, only IDLE_PATTERN is sent.
REQ-007 The block SHALL have port data_in  input  WIDTH  parallel word to serialise.
REQ-008 The block SHALL have port valid_in  input  1  data_in holds a word to send.
REQ-009 The block SHALL have port ready_out  output  1  the block accepts data_in on this cycle.
REQ-010 The block SHALL have port IDL  output  1  serial bit stream.
REQ-011 The block SHALL have port idle_out  output  1  the word currently on IDL is IDLE_PATTERN.
REQ-012 The block SHALL have port word_done  output  1  one-cycle pulse on the last bit of each word.
REQ-013 The block SHALL have port underrun_cnt  output  8  count of idle words inserted while active was high; the count saturates at 255.

Function
REQ-014 The block SHALL implement three states: RST, IDLE_TX and DATA_TX.
- IDLE_TX: the word being shifted is IDLE_PATTERN.
- DATA_TX: the word being shifted is user data.
REQ-015 The block SHALL keep a WIDTH-bit shift register and a bit counter bit_cnt of width $clog2(WIDTH) that counts 0..WIDTH-1 and wraps to 0.
REQ-016 A load boundary SHALL occur in RST and whenever bit_cnt==WIDTH-1.
REQ-017 The block SHALL drive ready_out combinationally, equal to (load boundary && active && !reset).
REQ-018 At a load boundary:
- if valid_in && ready_out, the block SHALL load data_in and go to DATA_TX;
- otherwise it SHALL load IDLE_PATTERN and go to IDLE_TX.
REQ-019 The block SHALL set bit_cnt to 0 on every load.
REQ-020 Timing of serial output:
- The first bit of a loaded word SHALL appear on IDL in the cycle after the load edge.
- Each subsequent bit SHALL appear on the next clk_32f cycle.
- Words SHALL follow back-to-back with no gap bits.
REQ-021 Bit order on IDL:
- LSB_FIRST=0: bit WIDTH-1-bit_cnt of the loaded word.
- LSB_FIRST=1: bit bit_cnt of the loaded word.
REQ-022 idle_out SHALL be 1 throughout every IDLE_TX word and throughout RST.
REQ-023 word_done SHALL be 1 exactly when bit_cnt==WIDTH-1 in IDLE_TX or DATA_TX.
REQ-024 underrun_cnt SHALL increment by 1 at a load boundary when active==1 and valid_in==0, and it SHALL hold at 255.
REQ-025 If active falls in the middle of a word, the current word SHALL complete unchanged and the next word SHALL be IDLE_PATTERN; no data SHALL be accepted while active==0.
REQ-026 If active and valid_in rise in the same cycle as a load boundary, the word SHALL be accepted on that cycle.
REQ-027 Changes on data_in or valid_in away from a load boundary SHALL have no effect on the word currently being shifted.
REQ-028 All outputs SHALL be glitch-free registered values, except ready_out, which is combinational per REQ-017.

Reset
REQ-029 When reset==1 at a clk_32f edge, on that edge:
- state SHALL become RST and bit_cnt 0;
- the shift register SHALL become IDLE_PATTERN;
- IDL, word_done and underrun_cnt SHALL become 0, and idle_out 1.
REQ-030 Reset SHALL abort an in-flight word immediately, and the aborted word SHALL not be resumed.
REQ-031 In the first cycle after reset falls, the block SHALL be at a load boundary (RST) and SHALL load per REQ-018.

Verification
REQ-032 With WIDTH=8, LSB_FIRST=0: hold reset 2 cycles, then active=1, valid_in=1, data_in=8'hA5 -> ready_out=1 on the first cycle; IDL = 1,0,1,0,0,1,0,1 on the next 8 cycles; word_done high on the 8th bit.
REQ-033 With active=0 for 24 cycles after reset -> IDL repeats 10111100 three times; idle_out=1 throughout; underrun_cnt=0.
REQ-034 With active=1, valid_in=0 for 300 words -> IDLE_PATTERN is sent continuously; underrun_cnt reaches 255 and holds.
REQ-035 With LSB_FIRST=1, data_in=8'h01, then 8'h80 back-to-back -> IDL = 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 with no gap.
REQ-036 With active dropping at bit 3 of word 8'hFF -> the remaining bits are all 1; the following word is 8'hBC; ready_out stays 0.
REQ-037 With reset asserted at bit 5 of a data word -> on the next edge IDL=0, idle_out=1, bit_cnt=0; after release, a new word is loaded on the first cycle.
